// File: rtl/alu_issue.sv
// alu_issue: issue controller that sits in front of a combinational datapath ALU.
// It latches one operation on start, drives ctl/a/b to the external ALU for a
// single EXEC cycle, captures the ALU return at the end of that cycle and
// reports it with a one-cycle done pulse.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request pulse; only looked at in IDLE
//   alu_op[1:0]         00 add, 01 sub, 10 R-type (decode funct), 11 reserved
//   funct[5:0]          R-type function field
//   src_a, src_b[31:0]  operands to latch on an accepted start
//   ctl[2:0]            ALU control (000 AND, 001 OR, 010 ADD, 110 SUB)
//   a, b[31:0]          registered ALU operands
//   alu_result, alu_zero  combinational return from the datapath ALU
//   busy, done, err, zero, result[31:0]  status and captured result
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [2:0]  ctl,
  output logic [31:0] a,
  output logic [31:0] b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        zero,
  output logic [31:0] result
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  ctl_q, ctl_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;
  logic        slt_q, slt_d;   // op in flight is SLT: result is built from the sign
  logic        bad_q, bad_d;   // op in flight was undecodable: skip the ALU capture

  // Operation decode
  logic [2:0] dec_ctl;
  logic       dec_bad;
  logic       dec_slt;

  always_comb begin
    dec_ctl = CTL_ADD;
    dec_bad = 1'b0;
    dec_slt = 1'b0;
    case (alu_op)
      2'b00: dec_ctl = CTL_ADD;
      2'b01: dec_ctl = CTL_SUB;
      2'b10: begin
        case (funct)
          6'b100000: dec_ctl = CTL_ADD;
          6'b100010: dec_ctl = CTL_SUB;
          6'b100100: dec_ctl = CTL_AND;
          6'b100101: dec_ctl = CTL_OR;
          6'b101010: begin
            dec_ctl = CTL_SUB;
            dec_slt = 1'b1;
          end
          default: dec_bad = 1'b1;
        endcase
      end
      default: dec_bad = 1'b1;
    endcase
  end

  // Signed less-than: when signs differ the subtraction may overflow, so the
  // sign of a alone decides; otherwise the sign of a-b is exact.
  logic lt;
  assign lt = (a_q[31] != b_q[31]) ? a_q[31] : alu_result[31];

  always_comb begin
    state_d  = state_q;
    ctl_d    = ctl_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    slt_d    = slt_q;
    bad_d    = bad_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = src_a;
          b_d     = src_b;
          ctl_d   = dec_ctl;
          slt_d   = dec_slt;
          bad_d   = dec_bad;
          err_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bad_q) begin
          result_d = 32'd0;
          zero_d   = 1'b0;
          err_d    = 1'b1;
        end else if (slt_q) begin
          result_d = {31'd0, lt};
          zero_d   = ~lt;
        end else begin
          result_d = alu_result;
          zero_d   = alu_zero;
        end
        // ctl returns to ADD so it already reads 010 once back in IDLE
        ctl_d   = CTL_ADD;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ctl_q    <= CTL_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      slt_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      slt_q    <= slt_d;
      bad_q    <= bad_d;
    end
  end

  assign ctl    = ctl_q;
  assign a      = a_q;
  assign b      = b_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign err    = err_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: the bench plays the datapath ALU; directed operations
// push their hand-computed {result, zero, err} into a queue and a monitor pops
// and compares whenever done is seen.
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b;
  logic [2:0]  ctl;
  logic [31:0] a, b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        busy, done, err, zero;
  logic [31:0] result;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .funct(funct),
    .src_a(src_a), .src_b(src_b), .ctl(ctl), .a(a), .b(b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .done(done), .err(err), .zero(zero), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath ALU
  always_comb begin
    case (ctl)
      3'b000:  alu_result = a & b;
      3'b001:  alu_result = a | b;
      3'b010:  alu_result = a + b;
      3'b110:  alu_result = a - b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("zero", {31'd0, zero}, {31'd0, e.zero});
        chk("err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // One operation: drive on negedge, check issue side, push expectation.
  task automatic do_op(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] sa, input logic [31:0] sb,
                       input logic [2:0] exp_ctl, input logic [31:0] exp_res,
                       input logic exp_zero, input logic exp_err);
    exp_t e;
    @(negedge clk);
    wait_idle();
    alu_op = op; funct = fn; src_a = sa; src_b = sb; start = 1'b1;
    e.res = exp_res; e.zero = exp_zero; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("exec_ctl", {29'd0, ctl}, {29'd0, exp_ctl});
    chk("exec_a", a, sa);
    chk("exec_b", b, sb);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("latency_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_ctl", {29'd0, ctl}, 32'd2);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ctl", {29'd0, ctl}, 32'd2);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; alu_op = 2'b00; funct = 6'd0;
    src_a = 32'd0; src_b = 32'd0;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    //     op     funct      src_a         src_b         ctl     result        z  e
    do_op(2'b10, 6'b100000, 32'd5,        32'd7,        3'b010, 32'd12,        0, 0);
    do_op(2'b01, 6'b000000, 32'h1234,     32'h1234,     3'b110, 32'd0,         1, 0);
    do_op(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        3'b110, 32'd1,         0, 0);
    do_op(2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 3'b110, 32'd0,         1, 0);
    do_op(2'b10, 6'b101010, 32'd3,        32'd5,        3'b110, 32'd1,         0, 0);
    do_op(2'b10, 6'b100100, 32'hF0F0FF00, 32'h0FF0F0F0, 3'b000, 32'h00F0F000,  0, 0);
    do_op(2'b10, 6'b100101, 32'hF0000000, 32'h0000000F, 3'b001, 32'hF000000F,  0, 0);
    do_op(2'b00, 6'b111111, 32'hFFFFFFFF, 32'd2,        3'b010, 32'd1,         0, 0);
    do_op(2'b10, 6'b100010, 32'd10,       32'd3,        3'b110, 32'd7,         0, 0);
    do_op(2'b10, 6'b000000, 32'd9,        32'd9,        3'b010, 32'd0,         0, 1);
    do_op(2'b11, 6'b100000, 32'd1,        32'd2,        3'b010, 32'd0,         0, 1);
    do_op(2'b00, 6'b000000, 32'd1,        32'd1,        3'b010, 32'd2,         0, 0);

    // start held high: one op per three cycles, busy 1,1,0 after each edge
    @(negedge clk);
    wait_idle();
    alu_op = 2'b10; funct = 6'b100000; src_a = 32'd5; src_b = 32'd7; start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_t'{32'd12, 1'b0, 1'b0});
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk("held_busy", {31'd0, busy}, (i % 3 == 2) ? 32'd0 : 32'd1);
    end
    start = 1'b0;
    @(negedge clk);

    // reset in the middle of EXEC: outputs clear at once, no done
    @(negedge clk);
    wait_idle();
    alu_op = 2'b00; funct = 6'd0; src_a = 32'd100; src_b = 32'd23; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    @(posedge clk); #1;
    chk("abort_no_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b00, 6'b000000, 32'd100,      32'd23,       3'b010, 32'd123,       0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
